wb_regfile_scoreboard: RTL and testbench

Architectural register file at the far end of the write-back bus. It accepts the registered WB write (register, data, valid) and serves two decode-stage read ports with write-through bypass. A per-register pending-write scoreboard tracks in-flight destinations from issue until write-back and raises a decode stall on RAW hazards. Sits between the WB stage register and the ID stage.

---
 rtl/wb_regfile_scoreboard.sv | 69 ++++++
 tb/tb_wb_regfile_scoreboard.sv | 137 +++++++++++++
 2 files changed

// File: rtl/wb_regfile_scoreboard.sv
// wb_regfile_scoreboard: architectural register file with WB write-through bypass and a per-register pending-write scoreboard
module wb_regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W = 32,
  parameter int MAX_INFLIGHT = 3,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        WB_write_reg_in,
  input  logic [DATA_W-1:0] WB_reg_write_data_in,
  input  logic              WB_register_write_valid_in,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic              issue_writes_rd,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              hazard_stall,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic              sb_underflow_err
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CW-1:0] cnt [NUM_REGS];
  logic [CW-1:0] c1, c2, cd;
  logic wb_fire, hit1, hit2, hitd, pend1, pend2, sat, issue_accept;
  logic [NUM_REGS-1:0] acc_v, ret_v;
  assign wb_fire = WB_register_write_valid_in && WB_write_reg_in != '0;
  assign hit1 = wb_fire && WB_write_reg_in == rs1_addr;
  assign hit2 = wb_fire && WB_write_reg_in == rs2_addr;
  assign hitd = wb_fire && WB_write_reg_in == issue_rd;
  assign c1 = cnt[rs1_addr];
  assign c2 = cnt[rs2_addr];
  assign cd = cnt[issue_rd];
  assign pend1 = c1 != '0 && !(c1 == CW'(1) && hit1);
  assign pend2 = c2 != '0 && !(c2 == CW'(1) && hit2);
  assign sat = cd == CW'(MAX_INFLIGHT) && !hitd;
  assign hazard_stall = issue_valid && ((rs1_used && rs1_addr != '0 && pend1) ||
                                        (rs2_used && rs2_addr != '0 && pend2) ||
                                        (issue_writes_rd && issue_rd != '0 && sat));
  assign issue_accept = issue_valid && !hazard_stall && issue_writes_rd && issue_rd != '0;
  assign acc_v = issue_accept ? NUM_REGS'(1) << issue_rd : '0;
  assign ret_v = wb_fire ? NUM_REGS'(1) << WB_write_reg_in : '0;
  assign rs1_data = rs1_addr == '0 ? '0 : hit1 ? WB_reg_write_data_in : regs[rs1_addr];
  assign rs2_data = rs2_addr == '0 ? '0 : hit2 ? WB_reg_write_data_in : regs[rs2_addr];
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) pending_mask[i] = cnt[i] != '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        cnt[i] <= '0;
      end
      sb_underflow_err <= 1'b0;
    end else begin
      if (wb_fire) regs[WB_write_reg_in] <= WB_reg_write_data_in;
      if (wb_fire && !acc_v[WB_write_reg_in] && cnt[WB_write_reg_in] == '0) sb_underflow_err <= 1'b1;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (acc_v[i] && !ret_v[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (ret_v[i] && !acc_v[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// tb_wb_regfile_scoreboard: directed table-driven vectors plus hand-written reset sequences
module tb_wb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] wr, r1, r2, ird;
  logic [31:0] wd;
  logic wv, u1, u2, iv, iw;
  logic [31:0] rs1_data, rs2_data, pending_mask;
  logic hazard_stall, sb_underflow_err;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic wv; logic [4:0] wr; logic [31:0] wd;
    logic [4:0] r1; logic u1; logic [4:0] r2; logic u2;
    logic iv; logic [4:0] ird; logic iw;
    logic [31:0] e1, e2; logic es; logic [31:0] em; logic ee;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  wb_regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .WB_write_reg_in(wr), .WB_reg_write_data_in(wd), .WB_register_write_valid_in(wv),
    .rs1_addr(r1), .rs2_addr(r2), .rs1_used(u1), .rs2_used(u2),
    .issue_valid(iv), .issue_rd(ird), .issue_writes_rd(iw),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .hazard_stall(hazard_stall),
    .pending_mask(pending_mask), .sb_underflow_err(sb_underflow_err)
  );

  function automatic vec_t mk(logic wv_, logic [4:0] wr_, logic [31:0] wd_,
                              logic [4:0] r1_, logic u1_, logic [4:0] r2_, logic u2_,
                              logic iv_, logic [4:0] ird_, logic iw_,
                              logic [31:0] e1_, logic [31:0] e2_, logic es_, logic [31:0] em_, logic ee_);
    vec_t v;
    v.wv = wv_; v.wr = wr_; v.wd = wd_; v.r1 = r1_; v.u1 = u1_; v.r2 = r2_; v.u2 = u2_;
    v.iv = iv_; v.ird = ird_; v.iw = iw_; v.e1 = e1_; v.e2 = e2_; v.es = es_; v.em = em_; v.ee = ee_;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wv = 0; wr = 0; wd = 0; r1 = 0; r2 = 0; u1 = 0; u2 = 0; iv = 0; ird = 0; iw = 0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    //       wv wr  wd            r1 u1 r2 u2 iv ird iw  e1            e2            es em           ee
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 5, 1,  32'h0,        32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 5, 32'hF,        5, 0, 0, 0, 0, 0, 0,  32'hF,        32'h0,        0, 32'h20,       0));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0, 5, 0, 0, 0, 0,  32'h0,        32'hF,        0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        5, 1, 0, 0, 1, 7, 1,  32'hF,        32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        7, 1, 0, 0, 1, 0, 0,  32'h0,        32'h0,        1, 32'h80,       0));
    vecs.push_back(mk(0, 0, 32'h0,        7, 0, 0, 0, 1, 0, 0,  32'h0,        32'h0,        0, 32'h80,       0));
    vecs.push_back(mk(1, 7, 32'h77,       7, 1, 0, 0, 1, 0, 0,  32'h77,       32'h0,        0, 32'h80,       0));
    vecs.push_back(mk(0, 0, 32'h0,        7, 0, 0, 0, 0, 0, 0,  32'h77,       32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 21, 0, 1, 21, 1, 32'h0,       32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 21, 32'hDEADBEEF, 0, 0, 21, 0, 0, 0, 0, 32'h0,       32'hDEADBEEF, 0, 32'h200000,   0));
    vecs.push_back(mk(0, 21, 32'h12345678, 0, 0, 21, 0, 0, 0, 0, 32'h0,       32'hDEADBEEF, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 9, 1,  32'h0,        32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 9, 1,  32'h0,        32'h0,        0, 32'h200,      0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 9, 1,  32'h0,        32'h0,        0, 32'h200,      0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 9, 1,  32'h0,        32'h0,        1, 32'h200,      0));
    vecs.push_back(mk(1, 9, 32'h99,       9, 0, 0, 0, 1, 9, 1,  32'h99,       32'h0,        0, 32'h200,      0));
    vecs.push_back(mk(1, 9, 32'h98,       0, 0, 9, 1, 1, 0, 0,  32'h0,        32'h98,       1, 32'h200,      0));
    vecs.push_back(mk(1, 9, 32'h97,       0, 0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 32'h200,      0));
    vecs.push_back(mk(1, 9, 32'h96,       9, 1, 0, 0, 1, 0, 0,  32'h96,       32'h0,        0, 32'h200,      0));
    vecs.push_back(mk(0, 0, 32'h0,        9, 0, 0, 0, 0, 0, 0,  32'h96,       32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 3, 32'h33,       3, 0, 0, 0, 0, 0, 0,  32'h33,       32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        3, 0, 0, 0, 1, 12, 1, 32'h33,       32'h0,        0, 32'h0,        1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 3, 0, 1, 0, 1,  32'h0,        32'h33,       0, 32'h1000,     1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 32'h1000,     1));

    repeat (2) @(posedge clk);
    #1;
    chk("reset rs1", rs1_data, 32'h0);
    chk("reset mask", pending_mask, 32'h0);
    chk("reset err", {31'h0, sb_underflow_err}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      wv = vecs[k].wv; wr = vecs[k].wr; wd = vecs[k].wd;
      r1 = vecs[k].r1; u1 = vecs[k].u1; r2 = vecs[k].r2; u2 = vecs[k].u2;
      iv = vecs[k].iv; ird = vecs[k].ird; iw = vecs[k].iw;
      #3;
      chk($sformatf("v%0d rs1", k), rs1_data, vecs[k].e1);
      chk($sformatf("v%0d rs2", k), rs2_data, vecs[k].e2);
      chk($sformatf("v%0d stall", k), {31'h0, hazard_stall}, {31'h0, vecs[k].es});
      chk($sformatf("v%0d mask", k), pending_mask, vecs[k].em);
      chk($sformatf("v%0d err", k), {31'h0, sb_underflow_err}, {31'h0, vecs[k].ee});
      @(posedge clk);
      #1;
    end

    // mid-run async reset: outputs must clear with no clock edge
    idle();
    r1 = 3; r2 = 21;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst rs1", rs1_data, 32'h0);
    chk("midrst rs2", rs2_data, 32'h0);
    chk("midrst mask", pending_mask, 32'h0);
    chk("midrst err", {31'h0, sb_underflow_err}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    r1 = 12; u1 = 1; iv = 1; iw = 0;
    #3;
    chk("postrst no stall x12", {31'h0, hazard_stall}, 32'h0);
    @(posedge clk);
    #1;
    idle();
    wv = 1; wr = 3; wd = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    idle();
    r1 = 3;
    #3;
    chk("postrst x3", rs1_data, 32'hA5A5A5A5);
    chk("postrst err", {31'h0, sb_underflow_err}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
